// File: rtl/ring_monitor.sv
// ring_monitor: legality checker, position encoder, lap counter and fault counter for an 8-bit one-hot ring.
// Build option: define RING_MON_HOLD_EN to accept a repeated vector (ring counter with clock-enable) as legal.
module ring_monitor #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ring,
  input  logic             clr_err,
  output logic [2:0]       pos,
  output logic             pos_vld,
  output logic             lap_tick,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       smp_q;
  logic [7:0]       prv_q, prv_d;
  logic [2:0]       pos_q, pos_d;
  logic             vld_q, vld_d;
  logic             tick_q, tick_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic             smp_oh_s;
  logic [2:0]       smp_idx_s;
  logic             step_ok_s;
  logic             hold_s;
  logic             err_ev_s;

  function automatic logic is_onehot(input logic [7:0] v);
    is_onehot = ($countones(v) == 32'd1);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] v);
    encode = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        encode = i[2:0];
      end
    end
  endfunction

  assign smp_oh_s  = is_onehot(smp_q);
  assign smp_idx_s = encode(smp_q);
  assign step_ok_s = (smp_q == {prv_q[6:0], prv_q[7]});

`ifdef RING_MON_HOLD_EN
  assign hold_s = (smp_q == prv_q);
`else
  assign hold_s = 1'b0;
`endif

  // Classify the sample against the last accepted vector and form next state.
  always_comb begin
    state_d  = state_q;
    prv_d    = prv_q;
    pos_d    = pos_q;
    vld_d    = vld_q;
    tick_d   = 1'b0;
    lap_d    = lap_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    err_ev_s = 1'b0;

    case (state_q)
      SYNC, FAULT: begin
        if (smp_oh_s) begin
          prv_d   = smp_q;
          pos_d   = smp_idx_s;
          vld_d   = 1'b1;
          state_d = TRACK;
        end else begin
          state_d = state_q;
        end
      end
      TRACK: begin
        if (!smp_oh_s) begin
          err_ev_s = 1'b1;
          vld_d    = 1'b0;
          state_d  = FAULT;
        end else if (step_ok_s) begin
          prv_d = smp_q;
          pos_d = smp_idx_s;
          if (prv_q == 8'h80) begin
            tick_d = 1'b1;
            lap_d  = lap_q + {{(LAP_W-1){1'b0}}, 1'b1};
          end else begin
            tick_d = 1'b0;
          end
        end else if (hold_s) begin
          prv_d = prv_q;
        end else begin
          // One-hot but out of sequence: resynchronise onto the new position.
          err_ev_s = 1'b1;
          prv_d    = smp_q;
          pos_d    = smp_idx_s;
        end
      end
      default: begin
        state_d = SYNC;
        vld_d   = 1'b0;
      end
    endcase

    // A fault in the same cycle as a clear wins and restarts the count at one.
    if (err_ev_s) begin
      err_d = 1'b1;
      if (clr_err) begin
        cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
      end else if (cnt_q == {ERR_W{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end else if (clr_err) begin
      err_d = 1'b0;
      cnt_d = {ERR_W{1'b0}};
    end else begin
      err_d = err_q;
    end
  end

  // Sample register and all state/output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_q   <= 8'd0;
      prv_q   <= 8'd0;
      state_q <= SYNC;
      pos_q   <= 3'd0;
      vld_q   <= 1'b0;
      tick_q  <= 1'b0;
      lap_q   <= {LAP_W{1'b0}};
      err_q   <= 1'b0;
      cnt_q   <= {ERR_W{1'b0}};
    end else begin
      smp_q   <= ring;
      prv_q   <= prv_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      vld_q   <= vld_d;
      tick_q  <= tick_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos      = pos_q;
  assign pos_vld  = vld_q;
  assign lap_tick = tick_q;
  assign lap_cnt  = lap_q;
  assign err      = err_q;
  assign err_cnt  = cnt_q;

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Checker and position encoder on the 8-bit one-hot output of the ring counter. It samples the ring vector every clock and does four things:
- verifies that the vector stays one-hot and advances legally;
- encodes the active bit to a 3-bit position;
- counts complete laps;
- flags and counts faults.

It sits directly downstream of the ring counter and feeds LED/debug logic and system health status.

## Interface
Parameters:
- LAP_W, 8, width of lap counter (wraps modulo 2^LAP_W)
- ERR_W, 4, width of error counter (saturates at 2^ERR_W-1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- ring  input  8  one-hot ring vector from the ring counter; bit0→bit1→…→bit7→bit0 is the legal rotation
- clr_err  input  1  synchronous clear of err and err_cnt
- pos  output  3  index of the active bit of the last accepted sample
- pos_vld  output  1  1 while tracking a valid one-hot vector
- lap_tick  output  1  one-cycle pulse on each bit7→bit0 step
- lap_cnt  output  LAP_W  completed laps since reset
- err  output  1  sticky fault flag
- err_cnt  output  ERR_W  number of fault events, saturating

## Operation
- Stage 1: `ring` is registered into `smp` every cycle.
- Stage 2: `smp` is classified against `prv`, the last accepted vector, and all outputs are registered.
- onehot(smp) is true when exactly one bit is set. The legal steps are:
  - rotl(prv), where rotl(10000000) = 00000001;
  - a hold (smp == prv), only when the hold feature is enabled (see Configuration).
- **SYNC** (reset state):
  - pos_vld = 0; no errors are raised.
  - On onehot(smp): prv ← smp, pos ← index, pos_vld ← 1, go to TRACK. No lap_tick is generated.
- **TRACK**:
  - Legal step: prv ← smp, pos ← index. If prv == 10000000 and smp == 00000001, then lap_tick ← 1 and lap_cnt ← lap_cnt + 1 (wraps).
  - One-hot but illegal step (jump, reverse, or a disallowed hold): this is an error event. prv and pos adopt smp (resynchronise), the state stays TRACK, and no lap is counted.
  - Not one-hot (zero or multi-bit): this is an error event. pos_vld ← 0, go to FAULT. pos and prv hold their last values.
- **FAULT**:
  - The first onehot(smp) does prv ← smp, pos ← index, pos_vld ← 1, go to TRACK. No error and no lap.
  - Further non-one-hot samples raise no additional errors.
- **Error event**: err ← 1; err_cnt ← err_cnt + 1, saturating at all-ones.
- **clr_err**:
  - err ← 0 and err_cnt ← 0.
  - If an error event occurs in the same cycle, the event wins: err = 1, err_cnt = 1.
  - clr_err has no effect on state, pos or lap_cnt.

## Timing
- rst is sampled low at a rising edge. That edge sets:
  - smp = 0, prv = 0, state = SYNC;
  - pos = 0, pos_vld = 0, lap_tick = 0, lap_cnt = 0, err = 0, err_cnt = 0.
- A mid-operation reset aborts tracking identically. The first sample after reset release is not compared to any pre-reset value.
- Latency: `ring` value V is present before edge k and captured into smp at edge k. Outputs reflecting V appear after edge k+1, which is 2 cycles.
- lap_tick is high for exactly one cycle per wrap. It coincides with the cycle in which lap_cnt shows the incremented value.
- With a free-running ring counter at one step per clock, lap_tick repeats every 8 cycles.
- An error reported in the cycle after edge k+1 corresponds to the sample captured at edge k.

## Configuration
- Macro: `RING_MON_HOLD_EN`.
- Defined: smp == prv is a legal step (ring counter with clock-enable). pos is unchanged, with no error and no lap.
- Not defined: every sample in TRACK must be rotl(prv). A hold is a one-hot illegal step, producing an error event with resync, and the state stays TRACK.

## Test plan
- **Reset then free-running ring.** rst low 2 cycles, then ring 00000001, 00000010, … one step per clock.
  - pos_vld rises 2 cycles after the first sample.
  - pos counts 0..7.
  - lap_tick pulses every 8 cycles; lap_cnt = 3 after 3 wraps; err = 0.
- **Jump.** While tracking at 00000100, drive 00100000.
  - err = 1, err_cnt = 1, pos = 5, pos_vld stays 1.
  - The next step, 01000000, is accepted without error.
- **Zero vector.** Drive 00000000 for 3 cycles, then 00001000.
  - err_cnt increments once and pos_vld = 0 for 3 cycles.
  - Tracking then resumes with pos = 3, pos_vld = 1, and no lap_tick.
- **Saturation and clear.**
  - 20 alternating jump faults leave err_cnt = 15.
  - clr_err alone gives err = 0, err_cnt = 0.
  - clr_err in the same cycle as a fault gives err = 1, err_cnt = 1.
- **Hold.** Repeat 00010000 for 2 cycles.
  - With RING_MON_HOLD_EN: no error, pos = 4.
  - Without it: err_cnt = 1.
- **Reset mid-lap.** Assert rst at pos = 6 with lap_cnt = 2.
  - All outputs read 0 the cycle after the reset edge.
  - After release, the first valid sample enters TRACK with no error.
